// File: rtl/key_decoder.sv
// PS/2 scancode decoder for a two-player game: synchronizes the byte-valid level,
// walks the E0/F0 prefix FSM and keeps ten held-key bits with a change pulse.
module key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [4:0] p1_keys,
  output logic [4:0] p2_keys,
  output logic       key_event
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_e;

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  // Key bit order: {p2 bomb,right,left,down,up, p1 bomb,right,left,down,up}.
  function automatic logic [9:0] base_mask(input logic [7:0] code);
    case (code)
      8'h1D:   base_mask = 10'b00000_00001;
      8'h1B:   base_mask = 10'b00000_00010;
      8'h1C:   base_mask = 10'b00000_00100;
      8'h23:   base_mask = 10'b00000_01000;
      8'h29:   base_mask = 10'b00000_10000;
      8'h5A:   base_mask = 10'b10000_00000;
      default: base_mask = '0;
    endcase
  endfunction

  function automatic logic [9:0] ext_mask(input logic [7:0] code);
    case (code)
      8'h75:   ext_mask = 10'b00001_00000;
      8'h72:   ext_mask = 10'b00010_00000;
      8'h6B:   ext_mask = 10'b00100_00000;
      8'h74:   ext_mask = 10'b01000_00000;
      default: ext_mask = '0;
    endcase
  endfunction

  logic [2:0]       sync_q, sync_d;
  logic             strobe_q, strobe_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       keys_q, keys_d;
  logic             event_q, event_d;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    sync_d   = {sync_q[1:0], data_valid};
    strobe_d = sync_q[1] & ~sync_q[2];
    state_d  = state_q;
    keys_d   = keys_q;
    cnt_d    = '0;

    if (strobe_q) begin
      if (data_in == 8'h00 || data_in == 8'hFF) begin
        keys_d  = '0;
        state_d = IDLE;
      end else begin
        case (state_q)
          // Status bytes (AA/FA/EE/FE) hit no map entry, so they fall through harmlessly.
          IDLE: begin
            if (data_in == B_EXT)      state_d = EXT;
            else if (data_in == B_BRK) state_d = BRK;
            else                       keys_d  = keys_q | base_mask(data_in);
          end
          EXT: begin
            if (data_in == B_BRK) begin
              state_d = EXT_BRK;
            end else begin
              keys_d  = keys_q | ext_mask(data_in);
              state_d = IDLE;
            end
          end
          BRK: begin
            keys_d  = keys_q & ~base_mask(data_in);
            state_d = IDLE;
          end
          EXT_BRK: begin
            keys_d  = keys_q & ~ext_mask(data_in);
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      // A stale prefix is dropped silently; a strobe on the same edge takes priority above.
      if (cnt_q == CNT_LAST) state_d = IDLE;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end

    event_d = (keys_d != keys_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, and every flop,
  // including the synchronizer, is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      strobe_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      keys_q   <= '0;
      event_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      strobe_q <= strobe_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      keys_q   <= keys_d;
      event_q  <= event_d;
    end
  end

  assign p1_keys   = keys_q[4:0];
  assign p2_keys   = keys_q[9:5];
  assign key_event = event_q;

endmodule

// File: tb/tb_key_decoder.sv
// Directed bench for key_decoder: table of scancodes with expected key vectors,
// plus hand-written timeout, reset and held-valid sequences.
module tb_key_decoder;

  localparam int unsigned TO = 16;

  logic       clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic [4:0] p1_keys;
  logic [4:0] p2_keys;
  logic       key_event;

  key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .p1_keys    (p1_keys),
    .p2_keys    (p2_keys),
    .key_event  (key_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;
  int seq_no = 0;

  always @(negedge clk) if (key_event === 1'b1) ev_cnt++;

  typedef struct {
    logic [7:0] b;
    logic [4:0] p1;
    logic [4:0] p2;
    int         ev;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic [4:0] p1, input logic [4:0] p2, input int ev);
    vec_t v;
    v.b = b; v.p1 = p1; v.p2 = p2; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Raises data_valid just before edge k, checks outputs unchanged after k+2
  // and updated after k+3, then drops valid and checks the event count.
  task automatic send_byte(input logic [7:0] b, input logic [4:0] e1, input logic [4:0] e2,
                           input int eev);
    logic [9:0] pre;
    int         ev0;
    string      nm;
    seq_no++;
    nm = $sformatf("byte%0d_%02h", seq_no, b);
    @(negedge clk);
    pre        = {p2_keys, p1_keys};
    ev0        = ev_cnt;
    data_in    = b;
    data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) check({nm, " k+2 keys"}, 32'({p2_keys, p1_keys}), 32'(pre));
      if (i == 3) begin
        check({nm, " p1"}, 32'(p1_keys), 32'(e1));
        check({nm, " p2"}, 32'(p2_keys), 32'(e2));
        check({nm, " event"}, 32'(key_event), 32'({e2, e1} != pre));
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    check({nm, " ev count"}, 32'(ev_cnt - ev0), 32'(eev));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("in reset p1", 32'(p1_keys), 32'd0);
    check("in reset p2", 32'(p2_keys), 32'd0);
    check("in reset event", 32'(key_event), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int ev0;
    reset_n    = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset p1", 32'(p1_keys), 32'd0);
    check("reset p2", 32'(p2_keys), 32'd0);
    check("reset event", 32'(key_event), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    add(8'h1D, 5'b00001, 5'b00000, 1);
    add(8'hF0, 5'b00001, 5'b00000, 0);
    add(8'h1D, 5'b00000, 5'b00000, 1);
    add(8'hE0, 5'b00000, 5'b00000, 0);
    add(8'h75, 5'b00000, 5'b00001, 1);
    add(8'hE0, 5'b00000, 5'b00001, 0);
    add(8'h74, 5'b00000, 5'b01001, 1);
    add(8'hE0, 5'b00000, 5'b01001, 0);
    add(8'hF0, 5'b00000, 5'b01001, 0);
    add(8'h75, 5'b00000, 5'b01000, 1);
    add(8'h29, 5'b10000, 5'b01000, 1);
    add(8'h29, 5'b10000, 5'b01000, 0);
    add(8'h29, 5'b10000, 5'b01000, 0);
    add(8'h1D, 5'b10001, 5'b01000, 1);
    add(8'h5A, 5'b10001, 5'b11000, 1);
    add(8'hE0, 5'b10001, 5'b11000, 0);
    add(8'h1D, 5'b10001, 5'b11000, 0);
    add(8'h75, 5'b10001, 5'b11000, 0);
    add(8'hAA, 5'b10001, 5'b11000, 0);
    add(8'hFE, 5'b10001, 5'b11000, 0);
    add(8'hE0, 5'b10001, 5'b11000, 0);
    add(8'h6B, 5'b10001, 5'b11100, 1);
    add(8'h00, 5'b00000, 5'b00000, 1);
    add(8'hFF, 5'b00000, 5'b00000, 0);
    add(8'hE0, 5'b00000, 5'b00000, 0);
    add(8'h00, 5'b00000, 5'b00000, 0);
    add(8'h75, 5'b00000, 5'b00000, 0);
    add(8'h1B, 5'b00010, 5'b00000, 1);
    add(8'hF0, 5'b00010, 5'b00000, 0);
    add(8'h1B, 5'b00000, 5'b00000, 1);

    foreach (vecs[i]) send_byte(vecs[i].b, vecs[i].p1, vecs[i].p2, vecs[i].ev);

    // data_valid held high for ten cycles must yield a single E0 strobe.
    @(negedge clk);
    data_in    = 8'hE0;
    data_valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    send_byte(8'h75, 5'b00000, 5'b00001, 1);
    send_byte(8'hE0, 5'b00000, 5'b00001, 0);
    send_byte(8'hF0, 5'b00000, 5'b00001, 0);
    send_byte(8'h75, 5'b00000, 5'b00000, 1);

    // Strobe on the exact timeout edge: decoded as extended.
    send_byte(8'hE0, 5'b00000, 5'b00000, 0);
    idle(5);
    send_byte(8'h75, 5'b00000, 5'b00001, 1);
    send_byte(8'hE0, 5'b00000, 5'b00001, 0);
    send_byte(8'hF0, 5'b00000, 5'b00001, 0);
    send_byte(8'h75, 5'b00000, 5'b00000, 1);

    // One edge later the prefix has expired, so 75 is unmapped.
    send_byte(8'hE0, 5'b00000, 5'b00000, 0);
    idle(6);
    send_byte(8'h75, 5'b00000, 5'b00000, 0);

    // Long silence after E0: no output change, then 1C is a plain left.
    send_byte(8'hE0, 5'b00000, 5'b00000, 0);
    ev0 = ev_cnt;
    idle(TO);
    check("timeout silence ev", 32'(ev_cnt - ev0), 32'd0);
    check("timeout silence keys", 32'({p2_keys, p1_keys}), 32'd0);
    send_byte(8'h1C, 5'b00100, 5'b00000, 1);
    send_byte(8'hF0, 5'b00100, 5'b00000, 0);
    send_byte(8'h1C, 5'b00000, 5'b00000, 1);

    // Reset after E0 F0 discards the prefix and clears held keys.
    send_byte(8'h1D, 5'b00001, 5'b00000, 1);
    send_byte(8'hE0, 5'b00001, 5'b00000, 0);
    send_byte(8'hF0, 5'b00001, 5'b00000, 0);
    pulse_reset();
    send_byte(8'h72, 5'b00000, 5'b00000, 0);
    send_byte(8'hE0, 5'b00000, 5'b00000, 0);
    send_byte(8'hF0, 5'b00000, 5'b00000, 0);
    pulse_reset();
    send_byte(8'h1D, 5'b00001, 5'b00000, 1);

    // data_valid already high at reset release still produces one strobe.
    @(negedge clk);
    reset_n    = 1'b0;
    data_in    = 8'h1B;
    data_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("valid at release p1", 32'(p1_keys), 32'b00010);
    @(negedge clk);
    data_valid = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_000_000, is the number of clk cycles a pending prefix (E0/F0) waits for its next byte before it is discarded.
REQ-002 clk  input  1  system clock, unrelated to the PS/2 clock domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data_in  input  8  scancode byte from the PS/2 receiver; held stable from the rise of data_valid until the next frame.
REQ-005 data_valid  input  1  PS/2-domain byte-valid level, high for at least one PS/2 clock period (≥30 µs), asynchronous to clk.
REQ-006 p1_keys  output  5  player-1 held keys {bomb,right,left,down,up}; 1 = pressed.
REQ-007 p2_keys  output  5  player-2 held keys {bomb,right,left,down,up}; 1 = pressed.
REQ-008 key_event  output  1  one-cycle pulse when any bit of p1_keys or p2_keys changes.

Function
REQ-009 data_valid shall pass through a 2-flop synchronizer; a third register shall detect its rising edge and form a one-cycle byte strobe.
- data_in is sampled only on the strobe.
- Ignoring data_in skew is safe because the bus is stable for ≥10 PS/2 clocks.
REQ-010 Latency: if edge k is the first to sample data_valid high, the key outputs and key_event shall update on edge k+3.
REQ-011 A data_valid level held high for many cycles shall produce exactly one strobe; a new strobe requires data_valid to go low and then high again.
REQ-012 The FSM shall have four states: IDLE, BRK (F0 seen), EXT (E0 seen) and EXT_BRK (E0 F0 seen).
REQ-013 FSM transitions on a strobe:
- IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code and the FSM stays in IDLE.
- EXT: F0 -> EXT_BRK; any other byte is an extended make code -> IDLE.
- BRK: any byte is a break code -> IDLE.
- EXT_BRK: any byte is an extended break code -> IDLE.
REQ-014 Non-extended map:
- 1D = p1 up, 1B = p1 down, 1C = p1 left, 23 = p1 right, 29 = p1 bomb.
- 5A = p2 bomb.
REQ-015 Extended map: E0 75 = p2 up, E0 72 = p2 down, E0 6B = p2 left, E0 74 = p2 right.
REQ-016 Make codes set the mapped bit and break codes clear it; unmapped codes change no output and still return the FSM to IDLE.
REQ-017 Typematic repeats of an already-set bit shall not pulse key_event.
- key_event is high only if the output vector value actually changes.
REQ-018 A non-extended code received in an extended state (e.g. E0 1D) shall be treated as unmapped.
- Likewise, an extended-only code received without the prefix (e.g. 75) shall be treated as unmapped.
REQ-019 Byte 00 or FF (receiver overrun), in any state, shall clear all ten key bits and force the FSM to IDLE.
- key_event pulses if any bit was set.
REQ-020 Bytes AA, FA, EE and FE received in IDLE shall be ignored.
REQ-021 Timeout counter:
- Cleared on every strobe.
- Counts while the FSM is not in IDLE.
- On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no output change.
REQ-022 If a strobe and the timeout coincide, the strobe shall win: the byte is decoded in the current state and the counter clears.
REQ-023 The counter width shall be sufficient for TIMEOUT_CYCLES with no wrap.
- The counter saturates in IDLE, where it is held at zero.

Reset
REQ-024 While reset_n is low, the outputs and internal state shall be as follows:
- p1_keys = 0, p2_keys = 0, key_event = 0.
- FSM = IDLE, timeout counter = 0, all synchronizer flops = 0.
REQ-025 Reset assertion mid-sequence (e.g. after E0 F0) shall discard the prefix.
- After release, the next byte is decoded from IDLE.
REQ-026 If data_valid is already high when reset_n releases, a strobe shall fire once the synchronizer fills.
- The design accepts this; the receiver clears data_valid on its own reset.

Verification
REQ-027 Byte 1D then F0 1D:
- p1_keys goes 00000 -> 00001 (event pulse) -> 00000 (event pulse).
- Each update lands 3 clks after the valid edge.
REQ-028 Bytes E0 75, E0 74, then E0 F0 75:
- p2_keys goes 00001 -> 01001 -> 01000.
- Three key_event pulses in total.
REQ-029 Byte 29 sent three times (typematic):
- p1_keys[4] = 1 after the first byte.
- Exactly one key_event pulse.
REQ-030 Byte E0 followed by a silence of TIMEOUT_CYCLES, then 1C:
- p1_keys[2] = 1 (decoded as non-extended left).
- No output change at the timeout.
REQ-031 Keys 1D and 5A held, then byte 00:
- Both vectors clear on the same edge.
- One key_event pulse.
REQ-032 Bytes E0 F0 then reset_n pulsed low, then 72:
- No output change (72 is unmapped outside an extended state).
- The FSM is in IDLE.
